// File: rtl/progmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : progmem_arb_pkg
// Purpose  : Shared types and constants for the program-RAM port-A arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package progmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RWAIT = 2'd2
    } arb_state_t;

    // Wide enough to count up to the largest supported READ_LATENCY (4)
    localparam int LAT_CNT_W   = 3;
    localparam int MAX_NUM_REQ = 8;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker; first set request after rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0] w_cand;

    // Scan from the farthest candidate to the nearest so the nearest one wins
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[w_cand[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/progmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : progmem_port_arbiter
// Purpose  : Round-robin sharing of M9K program RAM port A between requesters,
//            with burst lock and registered-read latency sequencing.
//            Optional write protection below wp_limit: define PROGMEM_ARB_WP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module progmem_port_arbiter
    import progmem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                          sysclk,
    input  logic                          sysreset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          mem_wren,
`ifdef PROGMEM_ARB_WP_EN
    input  logic [ADDR_WIDTH-1:0]         wp_limit,
    output logic                          wr_err,
`endif
    input  logic [DATA_WIDTH-1:0]         mem_q
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > MAX_NUM_REQ || READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_param
        $error("progmem_port_arbiter: parameter out of range");
    end

    arb_state_t             r_state, w_state_nxt;
    logic [c_IDX_W-1:0]     r_idx, r_rr_ptr, w_pick_idx, w_grant_idx;
    logic                   r_we, r_lock_hold;
    logic                   w_pick_any, w_lock_regrant, w_grant_vld, w_lat_done, w_wp_block;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata, r_rdata;
    logic [LAT_CNT_W-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  w_wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .any    (w_pick_any),
        .idx    (w_pick_idx)
    );

    // A locked requester that still asks keeps the port without arbitration
    assign w_lock_regrant = r_lock_hold & req[r_idx];
    assign w_grant_vld    = w_lock_regrant | w_pick_any;
    assign w_grant_idx    = w_lock_regrant ? r_idx : w_pick_idx;
    assign w_lat_done     = (r_state == ARB_RWAIT) && (r_cnt == LAT_CNT_W'(READ_LATENCY));

`ifdef PROGMEM_ARB_WP_EN
    assign w_wp_block = r_we && (r_addr < wp_limit);
`else
    assign w_wp_block = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ack         = '0;
        rvalid      = '0;
        mem_wren    = 1'b0;
`ifdef PROGMEM_ARB_WP_EN
        wr_err      = 1'b0;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                ack[r_idx]  = 1'b1;
                mem_wren    = r_we & ~w_wp_block;
`ifdef PROGMEM_ARB_WP_EN
                wr_err      = w_wp_block;
`endif
                w_state_nxt = r_we ? ARB_IDLE : ARB_RWAIT;
            end
            ARB_RWAIT: begin
                if (w_lat_done) begin
                    rvalid[r_idx] = 1'b1;
                    w_state_nxt   = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            r_idx       <= '0;
            r_rr_ptr    <= c_IDX_W'(NUM_REQ-1);
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_lock_hold <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_lock_hold <= 1'b0;
                    if (w_grant_vld) begin
                        r_idx    <= w_grant_idx;
                        r_rr_ptr <= w_grant_idx;
                        r_we     <= we[w_grant_idx];
                        r_addr   <= w_addr_arr[w_grant_idx];
                        r_wdata  <= w_wdata_arr[w_grant_idx];
                    end
                end
                ARB_ISSUE: begin
                    r_cnt <= LAT_CNT_W'(1);
                    // A write ends in ISSUE, so lock is sampled here
                    if (r_we) begin
                        r_lock_hold <= lock[r_idx];
                    end
                end
                ARB_RWAIT: begin
                    if (w_lat_done) begin
                        r_rdata     <= mem_q;
                        r_lock_hold <= lock[r_idx];
                    end else begin
                        r_cnt <= r_cnt + LAT_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data bypasses the holding register in the rvalid cycle
    assign rdata     = w_lat_done ? mem_q : r_rdata;
    assign busy      = (r_state != ARB_IDLE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire
